// File: rtl/reg_dump_uart.sv
// reg_dump_uart: walks the register file display port from FIRST_REG to LAST_REG.
// Each register is snapshotted once per line and sent as the 13-byte ASCII line
// "II:HHHHHHHH\r\n" on an 8N1 UART transmit pin.
//
// Handshake: iStart is a level request, sampled only while idle. oBusy is high
// from the cycle after acceptance until the dump completes. oDone pulses for one
// cycle after the last stop bit. Requests arriving while busy are dropped.
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 31
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [31:0] iRegData,
    output logic [4:0]  oRegSel,
    output logic        oTx,
    output logic        oBusy,
    output logic        oDone
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMR_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    FIRST_SEL = 5'(FIRST_REG);
    localparam logic [4:0]    LAST_SEL  = 5'(LAST_REG);
    localparam logic [3:0]    LAST_BYTE = 4'd12;
    localparam logic [3:0]    STOP_BIT  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CAPTURE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   bit_tmr;
    logic [3:0]      bit_cnt;
    logic [3:0]      byte_idx;
    logic [31:0]     snap;
    logic [7:0]      tx_shift;
    logic [7:0]      byte_nx;
    logic            bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign bit_end = (state == S_SEND) && (bit_tmr == TMR_LAST);

    // State register; reset drops any line in progress.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        oBusy    = 1'b0;
        oDone    = 1'b0;
        oTx      = 1'b1;
        case (state)
            S_IDLE: begin
                if (iStart) state_nx = S_SELECT;
            end
            S_SELECT: begin
                oBusy    = 1'b1;
                state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                oBusy    = 1'b1;
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                oBusy    = 1'b1;
                state_nx = S_SEND;
            end
            S_SEND: begin
                oBusy = 1'b1;
                if (bit_cnt == 4'd0)          oTx = 1'b0;
                else if (bit_cnt == STOP_BIT) oTx = 1'b1;
                else                          oTx = tx_shift[0];
                if (bit_end && (bit_cnt == STOP_BIT)) begin
                    if (byte_idx < LAST_BYTE)     state_nx = S_LOAD;
                    else if (oRegSel < LAST_SEL)  state_nx = S_SELECT;
                    else                          state_nx = S_DONE;
                end
            end
            S_DONE: begin
                oDone    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Character for the current byte position of the line.
    always_comb begin
        byte_nx = 8'h00;
        case (byte_idx)
            4'd0:    byte_nx = hex_ascii({3'b000, oRegSel[4]});
            4'd1:    byte_nx = hex_ascii(oRegSel[3:0]);
            4'd2:    byte_nx = 8'h3A;
            4'd3:    byte_nx = hex_ascii(snap[31:28]);
            4'd4:    byte_nx = hex_ascii(snap[27:24]);
            4'd5:    byte_nx = hex_ascii(snap[23:20]);
            4'd6:    byte_nx = hex_ascii(snap[19:16]);
            4'd7:    byte_nx = hex_ascii(snap[15:12]);
            4'd8:    byte_nx = hex_ascii(snap[11:8]);
            4'd9:    byte_nx = hex_ascii(snap[7:4]);
            4'd10:   byte_nx = hex_ascii(snap[3:0]);
            4'd11:   byte_nx = 8'h0D;
            4'd12:   byte_nx = 8'h0A;
            default: byte_nx = 8'h00;
        endcase
    end

    // Datapath: register select, snapshot, bit timing and byte shifting.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oRegSel  <= FIRST_SEL;
            bit_tmr  <= '0;
            bit_cnt  <= 4'd0;
            byte_idx <= 4'd0;
            snap     <= 32'h0;
            tx_shift <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iStart) oRegSel <= FIRST_SEL;
                end
                S_CAPTURE: begin
                    snap     <= iRegData;
                    byte_idx <= 4'd0;
                end
                S_LOAD: begin
                    tx_shift <= byte_nx;
                    bit_tmr  <= '0;
                    bit_cnt  <= 4'd0;
                end
                S_SEND: begin
                    if (bit_tmr == TMR_LAST) begin
                        bit_tmr <= '0;
                        if (bit_cnt == STOP_BIT) begin
                            bit_cnt <= 4'd0;
                            if (byte_idx < LAST_BYTE)    byte_idx <= byte_idx + 4'd1;
                            else if (oRegSel < LAST_SEL) oRegSel  <= oRegSel + 5'd1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt != 4'd0) tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
